// File: rtl/hazard_stall_controller.sv
// -----------------------------------------------------------------------------
// hazard_stall_controller
//
// Stall sequencer for the five-stage pipeline. Two jobs:
//   1. Load-use detection: a lw in Execute whose destination is read by the
//      instruction in Decode stalls PC/FD for one cycle and bubbles DX.
//   2. Mult/div handshake: a mul/div in Execute freezes PC/FD/DX while the
//      multi-cycle unit runs, then releases the pipeline for one DONE cycle
//      in which the XM latch captures the result.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   IR_Decode, IR_Execute        instructions in the FD and DX latches
//   md_resultRDY, md_exception   mult/div result-valid pulse and its error flag
//   stall_front                  hold PC and FD latch
//   hold_execute                 hold DX latch (mult/div stall only)
//   flush_execute                load a nop into DX (load-use stall only)
//   ctrl_MULT, ctrl_DIV          one-cycle start pulses (registered, state START)
//   md_latch_en                  XM takes the mult/div result (registered, DONE)
//   md_dest, md_status           writeback register and status value
//   lu_stall_count, md_stall_count  stall-cycle performance counters
//
// Parameter MD_TIMEOUT: BUSY cycles after which the operation is forced to
// complete with an exception.
//
// Optional feature: define STALL_PERF_EN to build the two stall counters.
// Without it both count outputs are tied to zero and no counter flops exist.
// -----------------------------------------------------------------------------
module hazard_stall_controller #(
    parameter int MD_TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] IR_Decode,
    input  logic [31:0] IR_Execute,
    input  logic        md_resultRDY,
    input  logic        md_exception,
    output logic        stall_front,
    output logic        hold_execute,
    output logic        flush_execute,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic        md_latch_en,
    output logic [4:0]  md_dest,
    output logic [31:0] md_status,
    output logic [31:0] lu_stall_count,
    output logic [31:0] md_stall_count
);

    localparam logic [4:0] OP_ALU = 5'b00000;
    localparam logic [4:0] OP_LW  = 5'b01000;
    localparam logic [4:0] OP_SW  = 5'b00111;
    localparam logic [4:0] OP_BNE = 5'b00010;
    localparam logic [4:0] OP_BLT = 5'b00110;
    localparam logic [4:0] OP_JR  = 5'b00100;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;
    localparam logic [4:0] REG_STATUS = 5'd30;
    localparam logic [31:0] TIMEOUT_LAST = 32'(MD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_DONE
    } state_t;

    state_t      state_q;
    logic [31:0] timer_q;
    logic        is_div_q;
    logic        ctrl_mult_q;
    logic        ctrl_div_q;
    logic        latch_q;
    logic [4:0]  dest_q;
    logic [31:0] status_q;

    // Instruction field decode
    logic [4:0] d_op, d_rd, d_rs, d_rt;
    logic [4:0] x_op, x_rd, x_alu;
    logic       x_is_mul, x_is_div, x_is_md, x_is_lw;
    logic       d_reads_rt, d_reads_rd, src_match;
    logic       md_stall, lu_stall;

    assign d_op  = IR_Decode[31:27];
    assign d_rd  = IR_Decode[26:22];
    assign d_rs  = IR_Decode[21:17];
    assign d_rt  = IR_Decode[16:12];
    assign x_op  = IR_Execute[31:27];
    assign x_rd  = IR_Execute[26:22];
    assign x_alu = IR_Execute[6:2];

    // Fields the controller never looks at
    logic unused_ir_bits;
    assign unused_ir_bits = ^{IR_Decode[11:0], IR_Execute[21:7], IR_Execute[1:0]};

    assign x_is_mul = (x_op == OP_ALU) && (x_alu == ALU_MUL);
    assign x_is_div = (x_op == OP_ALU) && (x_alu == ALU_DIV);
    assign x_is_md  = x_is_mul || x_is_div;
    assign x_is_lw  = (x_op == OP_LW);

    // R-type reads rt; stores and compare/jump-register forms read rd as a source
    assign d_reads_rt = (d_op == OP_ALU);
    assign d_reads_rd = (d_op == OP_SW) || (d_op == OP_BNE) ||
                        (d_op == OP_BLT) || (d_op == OP_JR);

    assign src_match = (x_rd == d_rs) ||
                       (d_reads_rt && (x_rd == d_rt)) ||
                       (d_reads_rd && (x_rd == d_rd));

    // The detect cycle (IDLE with mul/div in X) already stalls so the op is
    // held in DX while the start pulse goes out.
    assign md_stall = ((state_q == S_IDLE) && x_is_md) ||
                      (state_q == S_START) || (state_q == S_BUSY);

    // A lw and a mul/div cannot both sit in X, but the mask keeps the
    // priority explicit.
    assign lu_stall = x_is_lw && (x_rd != 5'd0) && src_match && !md_stall;

    assign stall_front   = md_stall || lu_stall;
    assign hold_execute  = md_stall;
    assign flush_execute = lu_stall;

    assign ctrl_MULT   = ctrl_mult_q;
    assign ctrl_DIV    = ctrl_div_q;
    assign md_latch_en = latch_q;
    assign md_dest     = dest_q;
    assign md_status   = status_q;

    // Mult/div FSM with registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            is_div_q    <= 1'b0;
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            latch_q     <= 1'b0;
            dest_q      <= '0;
            status_q    <= '0;
        end else begin
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            latch_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (x_is_md) begin
                        state_q     <= S_START;
                        dest_q      <= x_rd;
                        is_div_q    <= x_is_div;
                        ctrl_mult_q <= x_is_mul;
                        ctrl_div_q  <= x_is_div;
                    end
                end
                S_START: begin
                    // resultRDY is deliberately not looked at here
                    timer_q <= '0;
                    state_q <= S_BUSY;
                end
                S_BUSY: begin
                    timer_q <= timer_q + 32'd1;
                    if (md_resultRDY || (timer_q == TIMEOUT_LAST)) begin
                        state_q <= S_DONE;
                        latch_q <= 1'b1;
                        // A timeout without a result is reported as an exception
                        if (!md_resultRDY || md_exception) begin
                            dest_q   <= REG_STATUS;
                            status_q <= is_div_q ? 32'd5 : 32'd4;
                        end else begin
                            status_q <= '0;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef STALL_PERF_EN
    logic [31:0] lu_count_q;
    logic [31:0] md_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            lu_count_q <= '0;
            md_count_q <= '0;
        end else begin
            if (lu_stall) lu_count_q <= lu_count_q + 32'd1;
            if (md_stall) md_count_q <= md_count_q + 32'd1;
        end
    end

    assign lu_stall_count = lu_count_q;
    assign md_stall_count = md_count_q;
`else
    assign lu_stall_count = '0;
    assign md_stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller. A second instance with a short
// MD_TIMEOUT shares all stimulus and is used for the timeout scenario.
module tb_hazard_stall_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] ir_d, ir_x;
    logic        rdy, exc;

    logic        stall_front, hold_execute, flush_execute;
    logic        ctrl_MULT, ctrl_DIV, md_latch_en;
    logic [4:0]  md_dest;
    logic [31:0] md_status, lu_cnt, md_cnt;

    logic        stall_front_t, hold_execute_t, flush_execute_t;
    logic        ctrl_MULT_t, ctrl_DIV_t, md_latch_en_t;
    logic [4:0]  md_dest_t;
    logic [31:0] md_status_t, lu_cnt_t, md_cnt_t;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    hazard_stall_controller dut (
        .clock(clock), .reset(reset), .IR_Decode(ir_d), .IR_Execute(ir_x),
        .md_resultRDY(rdy), .md_exception(exc),
        .stall_front(stall_front), .hold_execute(hold_execute),
        .flush_execute(flush_execute), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .md_latch_en(md_latch_en), .md_dest(md_dest), .md_status(md_status),
        .lu_stall_count(lu_cnt), .md_stall_count(md_cnt)
    );

    hazard_stall_controller #(.MD_TIMEOUT(8)) dut_to (
        .clock(clock), .reset(reset), .IR_Decode(ir_d), .IR_Execute(ir_x),
        .md_resultRDY(rdy), .md_exception(exc),
        .stall_front(stall_front_t), .hold_execute(hold_execute_t),
        .flush_execute(flush_execute_t), .ctrl_MULT(ctrl_MULT_t), .ctrl_DIV(ctrl_DIV_t),
        .md_latch_en(md_latch_en_t), .md_dest(md_dest_t), .md_status(md_status_t),
        .lu_stall_count(lu_cnt_t), .md_stall_count(md_cnt_t)
    );

    // Instruction builders
    function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] alu);
        return {5'b00000, rd, rs, rt, 5'd0, alu, 2'b00};
    endfunction

    function automatic logic [31:0] i_type(input logic [4:0] op, input logic [4:0] rd,
                                           input logic [4:0] rs, input logic [16:0] imm);
        return {op, rd, rs, imm};
    endfunction

    // Two reset edges, inputs idle; returns at posedge+1 with reset released
    task automatic do_reset();
        reset = 1'b1; ir_d = '0; ir_x = '0; rdy = 1'b0; exc = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ir_d = '0; ir_x = '0; rdy = 1'b1; exc = 1'b1;
        @(posedge clock); #1;
        checks++;
        if ({stall_front, hold_execute, flush_execute, ctrl_MULT, ctrl_DIV,
             md_latch_en, md_dest, md_status} !== 42'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%0h exp=0", {stall_front, hold_execute,
                     flush_execute, ctrl_MULT, ctrl_DIV, md_latch_en, md_dest, md_status});
        end
        checks++;
        if ({lu_cnt, md_cnt} !== 64'd0) begin
            failures++;
            $display("FAIL reset_counts got=%0h/%0h exp=0/0", lu_cnt, md_cnt);
        end
        $display("test_reset done");
    endtask

    task automatic test_load_use();
        logic [31:0] lu_exp;
        do_reset();
        // lw r3 in X, add r5,r3,r4 in D
        ir_x = i_type(5'b01000, 5'd3, 5'd1, 17'd0);
        ir_d = r_type(5'd5, 5'd3, 5'd4, 5'd0);
        #1;
        checks++;
        if ({stall_front, hold_execute, flush_execute} !== 3'b101) begin
            failures++;
            $display("FAIL lu_rs got=%b exp=101", {stall_front, hold_execute, flush_execute});
        end
        @(posedge clock); #1;
        // lw moved on; the add is now in X with a nop behind it
        ir_x = r_type(5'd5, 5'd3, 5'd4, 5'd0);
        ir_d = '0;
        #1;
        checks++;
        if ({stall_front, hold_execute, flush_execute} !== 3'b000) begin
            failures++;
            $display("FAIL lu_clear got=%b exp=000", {stall_front, hold_execute, flush_execute});
        end
`ifdef STALL_PERF_EN
        lu_exp = 32'd1;
`else
        lu_exp = 32'd0;
`endif
        checks++;
        if (lu_cnt !== lu_exp) begin
            failures++;
            $display("FAIL lu_count got=%0d exp=%0d", lu_cnt, lu_exp);
        end
        // lw r0 never hazards
        ir_x = i_type(5'b01000, 5'd0, 5'd1, 17'd0);
        ir_d = r_type(5'd5, 5'd0, 5'd4, 5'd0);
        #1;
        checks++;
        if (stall_front !== 1'b0) begin
            failures++;
            $display("FAIL lu_r0 got=%b exp=0", stall_front);
        end
        // sw r3 reads r3 through its rd field
        ir_x = i_type(5'b01000, 5'd3, 5'd1, 17'd0);
        ir_d = i_type(5'b00111, 5'd3, 5'd1, 17'd0);
        #1;
        checks++;
        if ({stall_front, flush_execute} !== 2'b11) begin
            failures++;
            $display("FAIL lu_sw got=%b exp=11", {stall_front, flush_execute});
        end
        // R-type rt match
        ir_d = r_type(5'd5, 5'd4, 5'd3, 5'd0);
        #1;
        checks++;
        if ({stall_front, flush_execute} !== 2'b11) begin
            failures++;
            $display("FAIL lu_rt got=%b exp=11", {stall_front, flush_execute});
        end
        // addi: bits [16:12] are immediate, not rt
        ir_d = {5'b00101, 5'd5, 5'd4, 5'd3, 12'd0};
        #1;
        checks++;
        if (stall_front !== 1'b0) begin
            failures++;
            $display("FAIL lu_addi got=%b exp=0", stall_front);
        end
        // bne reads rd
        ir_d = i_type(5'b00010, 5'd3, 5'd2, 17'd0);
        #1;
        checks++;
        if (stall_front !== 1'b1) begin
            failures++;
            $display("FAIL lu_bne got=%b exp=1", stall_front);
        end
        $display("test_load_use done");
    endtask

    task automatic test_mul_17();
        int stalls = 0;
        int pulses = 0;
        logic [31:0] md_exp;
        do_reset();
        ir_d = r_type(5'd5, 5'd1, 5'd2, 5'd0);
        ir_x = r_type(5'd7, 5'd1, 5'd2, 5'b00110);
`ifdef STALL_PERF_EN
        md_exp = 32'd19;
`else
        md_exp = 32'd0;
`endif
        // c=0 detect, c=1 START, c=2..18 BUSY, c=19 DONE
        for (int c = 0; c < 20; c++) begin
            rdy = (c == 18);
            #1;
            if (c == 0) begin
                checks++;
                if ({stall_front, hold_execute, flush_execute} !== 3'b110) begin
                    failures++;
                    $display("FAIL mul_detect got=%b exp=110", {stall_front, hold_execute, flush_execute});
                end
            end
            stalls += int'(stall_front);
            pulses += int'(ctrl_MULT);
            if (c == 19) begin
                checks++;
                if (stalls !== 19 || pulses !== 1) begin
                    failures++;
                    $display("FAIL mul_stall_len got=%0d/%0d exp=19/1", stalls, pulses);
                end
                checks++;
                if ({stall_front, md_latch_en, md_dest, md_status} !== {1'b0, 1'b1, 5'd7, 32'd0}) begin
                    failures++;
                    $display("FAIL mul_done got=%b/%b/%0d/%0d exp=0/1/7/0",
                             stall_front, md_latch_en, md_dest, md_status);
                end
                checks++;
                if (md_cnt !== md_exp) begin
                    failures++;
                    $display("FAIL md_count got=%0d exp=%0d", md_cnt, md_exp);
                end
            end
            @(posedge clock); #1;
        end
        rdy = 1'b0; ir_x = '0; #1;
        checks++;
        if ({md_latch_en, stall_front} !== 2'b00) begin
            failures++;
            $display("FAIL mul_after got=%b exp=00", {md_latch_en, stall_front});
        end
        $display("test_mul_17 done");
    endtask

    task automatic test_div_exception();
        int stalls = 0;
        do_reset();
        ir_d = '0;
        ir_x = r_type(5'd9, 5'd1, 5'd2, 5'b00111);
        for (int c = 0; c < 4; c++) begin
            rdy = (c == 2);
            exc = (c == 2);
            #1;
            stalls += int'(stall_front);
            if (c == 1) begin
                checks++;
                if ({ctrl_DIV, ctrl_MULT} !== 2'b10) begin
                    failures++;
                    $display("FAIL div_pulse got=%b exp=10", {ctrl_DIV, ctrl_MULT});
                end
            end
            if (c == 3) begin
                checks++;
                if ({stalls == 3, md_latch_en, md_dest, md_status} !== {1'b1, 1'b1, 5'd30, 32'd5}) begin
                    failures++;
                    $display("FAIL div_exc got=%0d/%b/%0d/%0d exp=3/1/30/5",
                             stalls, md_latch_en, md_dest, md_status);
                end
            end
            @(posedge clock); #1;
        end
        rdy = 1'b0; exc = 1'b0; ir_x = '0;
        $display("test_div_exception done");
    endtask

    task automatic test_timeout();
        int stalls = 0;
        do_reset();
        ir_d = '0;
        ir_x = r_type(5'd7, 5'd1, 5'd2, 5'b00110);
        // short-timeout instance: c=2..9 BUSY, c=10 DONE
        for (int c = 0; c < 11; c++) begin
            #1;
            stalls += int'(stall_front_t);
            if (c == 9) begin
                checks++;
                if ({md_latch_en_t, stall_front_t} !== 2'b01) begin
                    failures++;
                    $display("FAIL to_busy got=%b exp=01", {md_latch_en_t, stall_front_t});
                end
            end
            if (c == 10) begin
                checks++;
                if ({stalls == 10, md_latch_en_t, md_dest_t, md_status_t} !== {1'b1, 1'b1, 5'd30, 32'd4}) begin
                    failures++;
                    $display("FAIL to_done got=%0d/%b/%0d/%0d exp=10/1/30/4",
                             stalls, md_latch_en_t, md_dest_t, md_status_t);
                end
            end
            @(posedge clock); #1;
        end
        ir_x = '0;
        $display("test_timeout done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        ir_d = '0;
        for (int c = 0; c < 8; c++) begin
            ir_x = (c < 4) ? r_type(5'd7, 5'd1, 5'd2, 5'b00110) : r_type(5'd8, 5'd1, 5'd2, 5'b00110);
            rdy = (c == 2) || (c == 6);
            #1;
            if (c == 3) begin
                checks++;
                if ({stall_front, md_latch_en, md_dest} !== {1'b0, 1'b1, 5'd7}) begin
                    failures++;
                    $display("FAIL b2b_first got=%b/%b/%0d exp=0/1/7", stall_front, md_latch_en, md_dest);
                end
            end
            if (c == 4) begin
                checks++;
                if ({stall_front, hold_execute, ctrl_MULT} !== 3'b110) begin
                    failures++;
                    $display("FAIL b2b_detect got=%b exp=110", {stall_front, hold_execute, ctrl_MULT});
                end
            end
            if (c == 5) begin
                checks++;
                if (ctrl_MULT !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_start got=%b exp=1", ctrl_MULT);
                end
            end
            if (c == 7) begin
                checks++;
                if ({md_latch_en, md_dest, md_status} !== {1'b1, 5'd8, 32'd0}) begin
                    failures++;
                    $display("FAIL b2b_second got=%b/%0d/%0d exp=1/8/0", md_latch_en, md_dest, md_status);
                end
            end
            @(posedge clock); #1;
        end
        rdy = 1'b0; ir_x = '0;
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        ir_d = '0;
        ir_x = r_type(5'd7, 5'd1, 5'd2, 5'b00110);
        @(posedge clock); #1;
        // now in START: reset must drop the start pulse
        reset = 1'b1; ir_x = '0;
        @(posedge clock); #1;
        checks++;
        if ({ctrl_MULT, ctrl_DIV} !== 2'b00) begin
            failures++;
            $display("FAIL rst_start got=%b exp=00", {ctrl_MULT, ctrl_DIV});
        end
        reset = 1'b0;
        ir_x = r_type(5'd7, 5'd1, 5'd2, 5'b00110);
        for (int c = 0; c < 4; c++) begin
            @(posedge clock); #1;
        end
        // in BUSY; reset, then a late result pulse
        reset = 1'b1; ir_x = '0;
        @(posedge clock); #1;
        reset = 1'b0; rdy = 1'b1;
        @(posedge clock); #1;
        rdy = 1'b0;
        #1;
        checks++;
        if ({stall_front, hold_execute, flush_execute, ctrl_MULT, ctrl_DIV,
             md_latch_en, md_dest, md_status} !== 42'd0) begin
            failures++;
            $display("FAIL rst_busy got=%0h exp=0", {stall_front, hold_execute,
                     flush_execute, ctrl_MULT, ctrl_DIV, md_latch_en, md_dest, md_status});
        end
        @(posedge clock); #1;
        checks++;
        if (md_latch_en !== 1'b0) begin
            failures++;
            $display("FAIL rst_late_rdy got=%b exp=0", md_latch_en);
        end
        $display("test_reset_mid_op done");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_use();
        test_mul_17();
        test_div_exception();
        test_timeout();
        test_back_to_back();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
